// File: rtl/cpu_bus_bridge_pkg.sv
// Package sc64: shared types and constants for the CPU bus bridge.
//   e_cpu_bridge_state  - bridge FSM states
//   CPU_BUS_FAULT_RDATA - read data handed to the CPU when a read is aborted
package sc64;

  typedef enum bit [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_READ  = 2'd1,
    S_WAIT_WRITE = 2'd2,
    S_POSTED     = 2'd3
  } e_cpu_bridge_state;

  localparam logic [31:0] CPU_BUS_FAULT_RDATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/cpu_bus_bridge_if.sv
// cpu_bus_bridge_if: CPU-side (picorv32 native) and bus-side (request/ack)
// signals of one bridge, plus fault reporting.
//   slave  - bridge view: consumes mem_* requests and bus_ack/bus_rdata
//   master - environment view (CPU core + interconnect)
interface cpu_bus_bridge_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_valid;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_wstrb;
  logic                  mem_ready;
  logic [31:0]           mem_rdata;
  logic                  bus_request;
  logic [ADDR_WIDTH-1:0] bus_address;
  logic [31:0]           bus_wdata;
  logic [3:0]            bus_wmask;
  logic                  bus_ack;
  logic [31:0]           bus_rdata;
  logic                  fault;
  logic [ADDR_WIDTH-1:0] fault_address;

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb, bus_ack, bus_rdata,
    output mem_ready, mem_rdata, bus_request, bus_address, bus_wdata, bus_wmask,
           fault, fault_address
  );

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb, bus_ack, bus_rdata,
    input  mem_ready, mem_rdata, bus_request, bus_address, bus_wdata, bus_wmask,
           fault, fault_address
  );
endinterface

// File: rtl/cpu_bus_bridge_timeout.sv
// cpu_bus_timeout: per-transaction wait counter with expiry compare.
//   clk, resetn - clock, async active-low reset
//   clear       - restart count (transaction accepted)
//   run         - count this cycle (waiting, no ack)
//   expired     - count has reached TIMEOUT_CYCLES
module cpu_bus_timeout #(
  parameter int TIMEOUT_CYCLES = 1023,
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic run,
  output logic expired
);
  logic [CW-1:0] cnt;

  assign expired = (cnt == CW'(TIMEOUT_CYCLES));

  // Saturates at expiry so a count left over after an abort cannot wrap.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                cnt <= '0;
    else if (clear)             cnt <= '0;
    else if (run && !expired)   cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/cpu_bus_bridge.sv
// cpu_bus_bridge: picorv32 mem_valid/mem_ready -> single-pulse request/ack bus.
// One-deep write posting (POST_WRITES), optional per-transaction timeout.
// Ports:
//   clk, resetn - clock, async active-low reset
//   bif         - cpu_bus_bridge_if.slave (mem_*, bus_*, fault, fault_address)
// Build option: CPU_BUS_TIMEOUT_EN enables the timeout/abort path; without it
// the bridge waits forever and fault/fault_address are tied 0.
module cpu_bus_bridge
  import sc64::*;
#(
  parameter int          ADDR_WIDTH     = 32,
  parameter bit          POST_WRITES    = 1'b1,
  parameter int          TIMEOUT_CYCLES = 1023,
  parameter logic [31:0] FAULT_RDATA    = CPU_BUS_FAULT_RDATA
) (
  input logic clk,
  input logic resetn,
  cpu_bus_bridge_if.slave bif
);
  e_cpu_bridge_state     state, state_d;
  logic                  ready_q, ready_d, req_q, req_d;
  logic [31:0]           rdata_q, rdata_d, wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            wmask_q, wmask_d;
  logic                  accept, expired;

  // No accept while mem_ready is high: the CPU still shows valid that cycle.
  assign accept = (state == S_IDLE) && bif.mem_valid && !ready_q;

`ifdef CPU_BUS_TIMEOUT_EN
  logic                  abort, fault_q;
  logic [ADDR_WIDTH-1:0] fault_addr_q;

  cpu_bus_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (accept),
    .run     ((state != S_IDLE) && !bif.bus_ack),
    .expired (expired)
  );

  // An ack arriving on the expiry cycle wins.
  assign abort = (state != S_IDLE) && expired && !bif.bus_ack;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      fault_q <= abort;
      if (abort) fault_addr_q <= addr_q;
    end
  end

  assign bif.fault         = fault_q;
  assign bif.fault_address = fault_addr_q;
`else
  // Timeout parameters are only meaningful with the timeout built in.
  logic unused_timeout_params;
  assign unused_timeout_params = ^{FAULT_RDATA, TIMEOUT_CYCLES};
  assign expired           = 1'b0;
  assign bif.fault         = 1'b0;
  assign bif.fault_address = '0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      ready_q <= 1'b0;
      req_q   <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state   <= state_d;
      ready_q <= ready_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

  always_comb begin
    state_d = state;
    ready_d = 1'b0;
    req_d   = 1'b0;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    case (state)
      S_IDLE: if (accept) begin
        req_d   = 1'b1;
        addr_d  = bif.mem_addr;
        wdata_d = bif.mem_wdata;
        wmask_d = bif.mem_wstrb;
        if (bif.mem_wstrb == 4'd0) state_d = S_WAIT_READ;
        else if (POST_WRITES) begin
          state_d = S_POSTED;
          ready_d = 1'b1;
          rdata_d = '0;
        end else state_d = S_WAIT_WRITE;
      end
      S_WAIT_READ: if (bif.bus_ack) begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        rdata_d = bif.bus_rdata;
      end else if (expired) begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        rdata_d = FAULT_RDATA;
      end
      S_WAIT_WRITE: if (bif.bus_ack || expired) begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        rdata_d = '0;
      end
      // CPU already released; only the bus side remains.
      S_POSTED: if (bif.bus_ack || expired) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bif.mem_ready   = ready_q;
  assign bif.mem_rdata   = rdata_q;
  assign bif.bus_request = req_q;
  assign bif.bus_address = addr_q;
  assign bif.bus_wdata   = wdata_q;
  assign bif.bus_wmask   = wmask_q;
endmodule

// File: tb/tb_cpu_bus_bridge.sv
// tb_cpu_bus_bridge: two bridges (blocking writes / posted writes) on shared
// stimulus; sel picks the one being checked. Expectations come from
// transaction-level timing rules (accept at cycle 0, request at 1, ack at
// 1+dly, ready one cycle after completion).
module tb_cpu_bus_bridge;
  localparam int AW = 32;
  localparam int TO = 8;
  localparam logic [31:0] FAULT_VAL = 32'hFFFF_FFFF;
`ifdef CPU_BUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0, resetn = 1'b0;
  always #5 clk = ~clk;

  logic          mem_valid = 0, bus_ack = 0;
  logic [AW-1:0] mem_addr = '0;
  logic [31:0]   mem_wdata = '0, bus_rdata = '0;
  logic [3:0]    mem_wstrb = '0;

  cpu_bus_bridge_if #(.ADDR_WIDTH(AW)) if0 ();
  cpu_bus_bridge_if #(.ADDR_WIDTH(AW)) if1 ();

  assign if0.mem_valid = mem_valid;  assign if1.mem_valid = mem_valid;
  assign if0.mem_addr  = mem_addr;   assign if1.mem_addr  = mem_addr;
  assign if0.mem_wdata = mem_wdata;  assign if1.mem_wdata = mem_wdata;
  assign if0.mem_wstrb = mem_wstrb;  assign if1.mem_wstrb = mem_wstrb;
  assign if0.bus_ack   = bus_ack;    assign if1.bus_ack   = bus_ack;
  assign if0.bus_rdata = bus_rdata;  assign if1.bus_rdata = bus_rdata;

  cpu_bus_bridge #(.ADDR_WIDTH(AW), .POST_WRITES(1'b0), .TIMEOUT_CYCLES(TO))
    dut0 (.clk(clk), .resetn(resetn), .bif(if0));
  cpu_bus_bridge #(.ADDR_WIDTH(AW), .POST_WRITES(1'b1), .TIMEOUT_CYCLES(TO))
    dut1 (.clk(clk), .resetn(resetn), .bif(if1));

  bit            sel;
  logic          o_ready, o_req, o_fault;
  logic [31:0]   o_rdata, o_wdata;
  logic [AW-1:0] o_addr, o_faddr;
  logic [3:0]    o_wmask;
  always_comb begin
    if (sel) begin
      o_ready = if1.mem_ready; o_req = if1.bus_request; o_fault = if1.fault;
      o_rdata = if1.mem_rdata; o_wdata = if1.bus_wdata; o_addr = if1.bus_address;
      o_faddr = if1.fault_address; o_wmask = if1.bus_wmask;
    end else begin
      o_ready = if0.mem_ready; o_req = if0.bus_request; o_fault = if0.fault;
      o_rdata = if0.mem_rdata; o_wdata = if0.bus_wdata; o_addr = if0.bus_address;
      o_faddr = if0.fault_address; o_wmask = if0.bus_wmask;
    end
  end

  int n_chk = 0, n_pass = 0;
  logic [31:0]   exp_rdata = '0;   // mem_rdata holds the last completion value
  logic [AW-1:0] exp_faddr = '0;   // sticky address of last abort

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " mem_ready"}, o_ready, 0);
    chk({tag, " bus_request"}, o_req, 0);
    chk({tag, " fault"}, o_fault, 0);
    chk({tag, " mem_rdata"}, o_rdata, 0);
    chk({tag, " bus_address"}, o_addr, 0);
    chk({tag, " bus_wdata"}, o_wdata, 0);
    chk({tag, " bus_wmask"}, o_wmask, 0);
    chk({tag, " fault_address"}, o_faddr, 0);
  endtask

  task automatic do_reset();
    resetn = 0; mem_valid = 0; bus_ack = 0; mem_wstrb = 0;
    tick(); tick();
    exp_rdata = '0; exp_faddr = '0;
    chk_zero("reset");
    resetn = 1;
    tick();
  endtask

  // One CPU transaction, entered with the bridge idle at a cycle boundary.
  // dly > TO (timeout builds only) means no ack in time, plus a late ack.
  task automatic cpu_txn(input logic [AW-1:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, input logic [31:0] rd, input int dly);
    bit posted, tmo;
    int ack_c, done_c, rdy_c, last;
    posted = sel && (ws != 4'd0);
    tmo    = TO_EN && (dly > TO);
    ack_c  = tmo ? TO + 3 : dly + 1;
    done_c = tmo ? TO + 2 : ack_c + 1;
    rdy_c  = posted ? 1 : done_c;
    last   = ((ack_c > done_c) ? ack_c : done_c) + 1;
    mem_valid = 1; mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
    for (int c = 1; c <= last; c++) begin
      tick();
      if (c == rdy_c) exp_rdata = (ws != 4'd0) ? 32'h0 : (tmo ? FAULT_VAL : rd);
      if (tmo && c == done_c) exp_faddr = a;
      chk("bus_request", o_req, c == 1);
      chk("mem_ready", o_ready, c == rdy_c);
      chk("mem_rdata", o_rdata, exp_rdata);
      chk("fault", o_fault, tmo && c == done_c);
      chk("fault_address", o_faddr, exp_faddr);
      if (c == 1) begin
        chk("bus_address", o_addr, a);
        chk("bus_wdata", o_wdata, wd);
        chk("bus_wmask", o_wmask, ws);
      end
      mem_valid = (c <= rdy_c);
      bus_ack   = (c == ack_c);
      bus_rdata = (c == ack_c) ? rd : $urandom;
    end
  endtask

  task automatic rand_txns(input int n);
    for (int i = 0; i < n; i++) begin
      logic [3:0] ws;
      ws = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      cpu_txn($urandom, $urandom, ws, $urandom, $urandom_range(0, 4));
    end
  endtask

  initial begin
    // ---- blocking-write bridge ----
    sel = 0;
    do_reset();
    cpu_txn(32'h1000_0004, 32'h0, 4'b0000, 32'hDEAD_BEEF, 2);
    cpu_txn(32'h2000_0010, 32'hCAFE_F00D, 4'b1111, 32'h0, 5);
    rand_txns(10);
`ifdef CPU_BUS_TIMEOUT_EN
    cpu_txn(32'h0800_0000, 32'h0, 4'b0000, 32'h1111_2222, 99);
    cpu_txn(32'h0800_0040, 32'h0, 4'b0000, 32'h3333_4444, 1);
    cpu_txn(32'h0800_0080, 32'h0, 4'b0000, 32'h5555_6666, TO);
    cpu_txn(32'h0900_0000, 32'hA5A5_A5A5, 4'b1000, 32'h0, 99);
`endif
    // reset while a read is outstanding
    mem_valid = 1; mem_addr = 32'h4000_0020; mem_wstrb = 4'b0000;
    tick();
    chk("mr_request", o_req, 1);
    tick();
    resetn = 0; #1;
    exp_rdata = '0; exp_faddr = '0;
    chk_zero("midreset");
    mem_valid = 0;
    tick(); tick();
    resetn = 1; bus_ack = 1; bus_rdata = 32'h7777_7777;
    tick();
    bus_ack = 0;
    chk("stray_ack ready", o_ready, 0);
    tick();
    chk("stray_ack ready2", o_ready, 0);
    chk("stray_ack rdata", o_rdata, 0);
    chk("stray_ack req", o_req, 0);

    // ---- posted-write bridge ----
    sel = 1;
    do_reset();
    mem_valid = 1; mem_addr = 32'h3000_0000; mem_wdata = 32'h1234_5678; mem_wstrb = 4'b0011;
    tick();
    chk("pw_req", o_req, 1); chk("pw_ready", o_ready, 1);
    chk("pw_wmask", o_wmask, 4'b0011); chk("pw_wdata", o_wdata, 32'h1234_5678);
    chk("pw_rdata", o_rdata, 0);
    mem_addr = 32'h3000_0100; mem_wstrb = 4'b0000;   // read issued straight away
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk("hold_req", o_req, 0); chk("hold_ready", o_ready, 0);
      bus_ack = (c == 3);
    end
    tick();
    chk("hr_req", o_req, 1); chk("hr_addr", o_addr, 32'h3000_0100); chk("hr_wmask", o_wmask, 0);
    bus_ack = 1; bus_rdata = 32'h0BAD_F00D;
    tick();
    bus_ack = 0;
    chk("hr_ready", o_ready, 1); chk("hr_rdata", o_rdata, 32'h0BAD_F00D);
    exp_rdata = 32'h0BAD_F00D;
    tick();
    chk("hr_guard_req", o_req, 0); chk("hr_guard_ready", o_ready, 0);
    mem_valid = 0;
    rand_txns(10);
`ifdef CPU_BUS_TIMEOUT_EN
    cpu_txn(32'h0A00_0000, 32'h0F0F_0F0F, 4'b0001, 32'h0, 99);
    cpu_txn(32'h0A00_0004, 32'h0, 4'b0000, 32'h2468_ACE0, 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
